// File: rtl/mm_sequencer.sv
// Sequences one N x N matrix-multiply job: streams operand pairs into the multiplier,
// waits for its result strobe, then reads the result matrix out row-major.
module mm_sequencer #(
  parameter int unsigned LOG_SIZE = 2,
  parameter int unsigned TIMEOUT  = 1023
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                out_sel_i,
  input  logic [31:0]         host_a_i,
  input  logic [31:0]         host_b_i,
  input  logic                host_valid_i,
  output logic                host_ready_o,
  output logic [31:0]         mm_a_o,
  output logic [31:0]         mm_b_o,
  output logic                mm_in_stb_o,
  input  logic                mm_in_ack_i,
  input  logic                mm_out_stb_i,
  output logic                mm_out_ack_o,
  output logic [LOG_SIZE-1:0] mm_row_o,
  output logic [LOG_SIZE-1:0] mm_column_o,
  input  logic [31:0]         mm_out_number_i,
  output logic                mm_output_select_o,
  output logic [31:0]         res_data_o,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic                res_last_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);

  localparam int unsigned     CntW      = 2 * LOG_SIZE;
  localparam logic [CntW-1:0] LastIdx   = {CntW{1'b1}};
  localparam logic [15:0]     WaitLimit = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StWait, StAddr, StHold, StFin} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   load_cnt_q, load_cnt_d;
  logic [CntW-1:0]   idx_q, idx_d;
  logic [15:0]       wait_cnt_q, wait_cnt_d;
  logic              out_sel_q, out_sel_d;
  logic              err_q, err_d;
  logic [31:0]       res_data_q, res_data_d;
  logic              res_valid_q, res_valid_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      load_cnt_q  <= '0;
      idx_q       <= '0;
      wait_cnt_q  <= '0;
      out_sel_q   <= 1'b0;
      err_q       <= 1'b0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      idx_q       <= idx_d;
      wait_cnt_q  <= wait_cnt_d;
      out_sel_q   <= out_sel_d;
      err_q       <= err_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    load_cnt_d   = load_cnt_q;
    idx_d        = idx_q;
    wait_cnt_d   = wait_cnt_q;
    out_sel_d    = out_sel_q;
    err_d        = err_q;
    res_data_d   = res_data_q;
    res_valid_d  = res_valid_q;
    host_ready_o = 1'b0;
    mm_in_stb_o  = 1'b0;
    mm_a_o       = '0;
    mm_b_o       = '0;
    mm_out_ack_o = 1'b0;
    done_o       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d    = StLoad;
          err_d      = 1'b0;
          load_cnt_d = '0;
          wait_cnt_d = '0;
          idx_d      = '0;
          out_sel_d  = out_sel_i;
        end
      end
      StLoad: begin
        // Operand path is a pure pass-through; the multiplier owns the handshake.
        host_ready_o = mm_in_ack_i;
        mm_in_stb_o  = host_valid_i;
        mm_a_o       = host_a_i;
        mm_b_o       = host_b_i;
        if (host_valid_i && mm_in_ack_i) begin
          if (load_cnt_q == LastIdx) begin
            load_cnt_d = '0;
            wait_cnt_d = '0;
            state_d    = StWait;
          end else begin
            load_cnt_d = load_cnt_q + CntW'(1);
          end
        end
      end
      StWait: begin
        if (mm_out_stb_i) begin
          wait_cnt_d = '0;
          state_d    = StAddr;
        end else if (wait_cnt_q == WaitLimit) begin
          wait_cnt_d = '0;
          err_d      = 1'b1;
          state_d    = StIdle;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      StAddr: begin
        // Row/column have been stable for a cycle, so the read data has settled.
        res_data_d  = mm_out_number_i;
        res_valid_d = 1'b1;
        state_d     = StHold;
      end
      StHold: begin
        if (res_valid_q && res_ready_i) begin
          res_valid_d = 1'b0;
          if (idx_q == LastIdx) begin
            state_d = StFin;
          end else begin
            idx_d   = idx_q + CntW'(1);
            state_d = StAddr;
          end
        end
      end
      StFin: begin
        mm_out_ack_o = 1'b1;
        done_o       = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign mm_row_o           = idx_q[CntW-1:LOG_SIZE];
  assign mm_column_o        = idx_q[LOG_SIZE-1:0];
  assign mm_output_select_o = out_sel_q;
  assign res_data_o         = res_data_q;
  assign res_valid_o        = res_valid_q;
  assign res_last_o         = res_valid_q && (idx_q == LastIdx);
  assign busy_o             = (state_q != StIdle);
  assign err_o              = err_q;

endmodule
